rr_arbiter: RTL

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/arb_pkg.sv | 30 +++
 rtl/rr_pick.sv | 50 +++++
 rtl/rr_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg -- shared definitions for the round-robin arbiter slice.
//
// Contents:
//   arb_state_e       : arbiter FSM encoding (IDLE = 0, GRANT = 1)
//   ARB_N_DEF         : default number of requesters
//   ARB_HOLD_MAX_DEF  : default maximum grant length, in cycles, used when
//                       the grant timeout (RR_ARBITER_TIMEOUT_EN) is built in
//   ARB_N_MIN/MAX     : legal requester count range
//   ARB_HOLD_MIN/MAX  : legal HOLD_MAX range (the hold counter is 8 bits)
//   ARB_CNT_W         : width of the hold counter
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int ARB_N_DEF        = 4;
  localparam int ARB_HOLD_MAX_DEF = 8;

  localparam int ARB_N_MIN        = 2;
  localparam int ARB_N_MAX        = 8;
  localparam int ARB_HOLD_MIN     = 2;
  localparam int ARB_HOLD_MAX     = 255;

  localparam int ARB_CNT_W        = 8;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick -- combinational wrap-around priority search.
//
// Scans req starting at bit ptr and moving upward, wrapping from N-1 back to
// 0, and returns the first set bit found. ptr therefore holds the highest
// priority and ptr-1 (mod N) the lowest. Holds no state.
//
// Parameters:
//   N       number of requesters (2..8)
//
// Ports:
//   req     in  [N-1:0]          request vector
//   ptr     in  [$clog2(N)-1:0]  highest-priority requester index
//   win     out [N-1:0]          one-hot winner, all zeros when req == 0
//   win_id  out [$clog2(N)-1:0]  index of the winner, 0 when req == 0
// -----------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = ARB_N_DEF
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win,
  output logic [$clog2(N)-1:0] win_id
);

  localparam int IDW = $clog2(N);

  logic           found;
  logic [IDW-1:0] idx;

  // idx walks ptr, ptr+1, ... modulo N; the first requesting index wins and
  // later hits are masked by 'found'. ptr is always < N, so idx stays in range.
  always_comb begin
    win    = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_id   = idx;
      end
    end
  end

endmodule : rr_pick

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter -- round-robin arbiter for one shared resource.
//
// A two-state FSM (IDLE / GRANT) hands the resource to one requester at a
// time. The winner is the first requester at or above the priority pointer,
// wrapping modulo N; every grant to requester k moves the pointer to k+1 so
// that k has the lowest priority next time round. The owner keeps the grant
// until it pulses done[owner] or drops req[owner]. When the owner releases
// and other requests are pending, the next winner is granted on the same edge
// so there is no idle cycle between owners.
//
// Build option:
//   RR_ARBITER_TIMEOUT_EN  when defined, a hold counter limits a grant to
//                          HOLD_MAX cycles; on expiry the grant is released
//                          as if the owner had let go and tmo pulses for one
//                          cycle. When undefined, grants are unbounded and
//                          tmo is tied low.
//
// Handshake: the requester raises req[i] and keeps it high while it wants
// the resource; it owns the resource while gnt[i] is high. A release is
// done[i]=1 or req[i]=0 sampled on a rising CLK edge while gnt[i]=1; done
// from a non-owner, or while idle, has no effect.
//
// Parameters:
//   N         number of requesters (2..8)
//   HOLD_MAX  maximum grant length in cycles (2..255), timeout build only
//
// Ports:
//   CLK        in   clock, rising edge
//   R          in   asynchronous active-low reset
//   req        in   [N-1:0] request vector
//   done       in   [N-1:0] release strobes
//   gnt        out  [N-1:0] one-hot grant, registered, 0 when idle
//   gnt_id     out  [$clog2(N)-1:0] owner index, registered, 0 when idle
//   busy       out  high while a grant is held, registered
//   tmo        out  one-cycle pulse after a forced (timeout) release
//   state_dbg  out  current FSM state (0 = IDLE, 1 = GRANT)
// -----------------------------------------------------------------------------
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int HOLD_MAX = ARB_HOLD_MAX_DEF
) (
  input  logic                 CLK,
  input  logic                 R,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 tmo,
  output logic                 state_dbg
);

  localparam int IDW = $clog2(N);

  // Out-of-range parameters stop elaboration.
  if (N < ARB_N_MIN || N > ARB_N_MAX ||
      HOLD_MAX < ARB_HOLD_MIN || HOLD_MAX > ARB_HOLD_MAX) begin : g_bad_param
    $error("rr_arbiter: N or HOLD_MAX out of range");
  end

  arb_state_e     state;
  logic [IDW-1:0] ptr;

  // ---------------------------------------------------------------------------
  // Winner search from the current priority pointer
  // ---------------------------------------------------------------------------
  logic [N-1:0]   pick_win;
  logic [IDW-1:0] pick_id;
  logic [IDW-1:0] pick_ptr_nxt;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .win    (pick_win),
    .win_id (pick_id)
  );

  // Pointer moves to one past the winner, wrapping at N.
  assign pick_ptr_nxt = (pick_id == IDW'(N - 1)) ? '0 : pick_id + 1'b1;

  // ---------------------------------------------------------------------------
  // Release detection
  // ---------------------------------------------------------------------------
  // Masking with gnt selects the owner's bits; both terms are 0 in IDLE
  // because gnt is 0 there, so foreign or idle done is ignored naturally.
  logic owner_req;
  logic owner_done;
  logic rel_nat;
  logic rel_tmo;
  logic rel;
  logic any_req;

  assign owner_req  = |(req & gnt);
  assign owner_done = |(done & gnt);
  assign any_req    = |req;
  assign rel_nat    = (state == GRANT) && (owner_done || !owner_req);
  assign rel        = rel_nat || rel_tmo;

`ifdef RR_ARBITER_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Hold counter: number of completed GRANT cycles of the current owner,
  // minus one. It reads HOLD_MAX-1 on the edge that closes the HOLD_MAX-th
  // cycle, which is where the forced release happens. A natural release on
  // that same edge wins, so tmo only reports releases the owner did not ask
  // for.
  // ---------------------------------------------------------------------------
  logic [ARB_CNT_W-1:0] hold_cnt;

  assign rel_tmo = (state == GRANT) && !rel_nat &&
                   (hold_cnt == ARB_CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      hold_cnt <= '0;
    end else if (state == IDLE || rel) begin
      // Either idle, or a new grant (possibly none) starts on this edge.
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign rel_tmo = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbiter FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
      tmo    <= 1'b0;
    end else begin
      tmo <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= GRANT;
            gnt    <= pick_win;
            gnt_id <= pick_id;
            busy   <= 1'b1;
            ptr    <= pick_ptr_nxt;
          end
        end

        GRANT: begin
          if (rel) begin
            tmo <= rel_tmo;
            // ptr already points past the owner, so a still-requesting
            // owner is found last and only wins when it is alone.
            if (any_req) begin
              gnt    <= pick_win;
              gnt_id <= pick_id;
              ptr    <= pick_ptr_nxt;
            end else begin
              state  <= IDLE;
              gnt    <= '0;
              gnt_id <= '0;
              busy   <= 1'b0;
            end
          end
        end

        default: begin
          state  <= IDLE;
          gnt    <= '0;
          gnt_id <= '0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule : rr_arbiter
